// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard/handshake bundle between the pipeline datapath and the
// stall/flush scheduler.
//   slave  : scheduler side (takes hazard events, drives controls/status)
//   master : datapath side (drives hazard events, takes controls/status)
// Signals: load_use, branch_taken, if_valid, mem_req, mem_ready (events);
//   pc_we, fs_ds_we/flush, ds_ex_we/flush, ex_mem_we, mem_wb_we/flush
//   (register controls); dmem_timeout, stall_cnt, flush_cnt, state (status).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use;
  logic             branch_taken;
  logic             if_valid;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_we;
  logic             fs_ds_we;
  logic             fs_ds_flush;
  logic             ds_ex_we;
  logic             ds_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             mem_wb_flush;
  logic             dmem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport slave (
    input  load_use, branch_taken, if_valid, mem_req, mem_ready,
    output pc_we, fs_ds_we, fs_ds_flush, ds_ex_we, ds_ex_flush,
           ex_mem_we, mem_wb_we, mem_wb_flush,
           dmem_timeout, stall_cnt, flush_cnt, state
  );

  modport master (
    output load_use, branch_taken, if_valid, mem_req, mem_ready,
    input  pc_we, fs_ds_we, fs_ds_flush, ds_ex_we, ds_ex_flush,
           ex_mem_we, mem_wb_we, mem_wb_flush,
           dmem_timeout, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous reset, active-high
//   bus  - pipe_hazard_ctrl_if.slave: hazard events in, pipe register
//          write-enable/flush controls, timeout flag, counters, state out
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_RST_FLUSH | post-reset: flush every pipe register, hold PC
// S_RUN       | normal issue, hazard priority dmem > load-use > branch > fetch
// S_DMEM_WAIT | data memory stalling; watchdog counting
// S_HALT      | watchdog expired; pipeline frozen until reset
module pipe_hazard_ctrl #(
  parameter int RST_FLUSH_CYC = 2,
  parameter int MAX_WAIT      = 16,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RST_FLUSH = 2'd0,
    S_RUN       = 2'd1,
    S_DMEM_WAIT = 2'd2,
    S_HALT      = 2'd3
  } state_e;

  localparam int RW = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_FLUSH_CYC - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic dmem_stall;
  logic pc_we, fs_ds_we, fs_ds_flush, ds_ex_we, ds_ex_flush;
  logic ex_mem_we, mem_wb_we, mem_wb_flush;

  // mem_req low counts as a completed access
  assign dmem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    wait_d       = wait_q;
    tmo_d        = tmo_q;
    pc_we        = 1'b0;
    fs_ds_we     = 1'b0;
    fs_ds_flush  = 1'b0;
    ds_ex_we     = 1'b0;
    ds_ex_flush  = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    mem_wb_flush = 1'b0;

    unique case (state_q)
      S_RST_FLUSH: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN, S_DMEM_WAIT: begin
        if (dmem_stall) begin
          mem_wb_we    = 1'b1;
          mem_wb_flush = 1'b1;
        end else begin
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
          ds_ex_we  = 1'b1;
          // load-use outranks branch: ID operands of the branch are stale
          if (bus.load_use) begin
            ds_ex_flush = 1'b1;
          end else begin
            fs_ds_we = 1'b1;
            if (bus.branch_taken) begin
              pc_we       = 1'b1;
              fs_ds_flush = 1'b1;
            end else if (!bus.if_valid) begin
              fs_ds_flush = 1'b1;
            end else begin
              pc_we = 1'b1;
            end
          end
        end

        if (state_q == S_RUN) begin
          if (dmem_stall) begin
            state_d = S_DMEM_WAIT;
            wait_d  = WW'(1);
          end
        end else if (!dmem_stall) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q + 1'b1 == WAIT_MAX) begin
            state_d = S_HALT;
            tmo_d   = 1'b1;
          end
        end
      end
      S_HALT: begin
      end
      default: state_d = S_RST_FLUSH;
    endcase

    // reset pattern shows as soon as rst is seen, not one cycle later
    if (rst || state_q == S_RST_FLUSH) begin
      pc_we        = 1'b0;
      fs_ds_we     = 1'b1;
      fs_ds_flush  = 1'b1;
      ds_ex_we     = 1'b1;
      ds_ex_flush  = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      mem_wb_flush = 1'b1;
    end

    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != S_RST_FLUSH && !pc_we && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if ((state_q == S_RUN || state_q == S_DMEM_WAIT) &&
        (fs_ds_flush || ds_ex_flush) && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST_FLUSH;
      rst_cnt_q <= '0;
      wait_q    <= '0;
      tmo_q     <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.fs_ds_we     = fs_ds_we;
  assign bus.fs_ds_flush  = fs_ds_flush;
  assign bus.ds_ex_we     = ds_ex_we;
  assign bus.ds_ex_flush  = ds_ex_flush;
  assign bus.ex_mem_we    = ex_mem_we;
  assign bus.mem_wb_we    = mem_wb_we;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.dmem_timeout = tmo_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
  assign bus.state        = state_q;

endmodule
